// File: rtl/lsu_bus_fsm.sv
// Load/store unit bus FSM: accepts EX-stage ops, issues one memory request per
// load/store, aligns store data/mask and extracts/extends load data on retire.
module lsu_bus_fsm #(
   parameter int unsigned CPU_WIDTH = 64,
   parameter int unsigned REG_ADDRW = 5
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   // EX-side handshake and op fields
   input  logic                 i_exu_valid,
   output logic                 o_exu_ready,
   input  logic [CPU_WIDTH-1:0] i_exu_exres,
   input  logic [CPU_WIDTH-1:0] i_exu_stdata,
   input  logic [REG_ADDRW-1:0] i_exu_rdid,
   input  logic                 i_exu_rdwen,
   input  logic                 i_exu_lden,
   input  logic                 i_exu_sten,
   input  logic [2:0]           i_exu_lsfunc,
   input  logic [CPU_WIDTH-1:0] i_exu_diffpc,
   // LS/WB pipeline register inputs
   output logic [CPU_WIDTH-1:0] o_lsu_exres,
   output logic [CPU_WIDTH-1:0] o_lsu_lsres,
   output logic [REG_ADDRW-1:0] o_lsu_rdid,
   output logic                 o_lsu_rdwen,
   output logic                 o_lsu_lden,
   output logic [CPU_WIDTH-1:0] s_lsu_diffpc,
   // Memory request / response
   output logic                 o_mem_req_valid,
   input  logic                 i_mem_req_ready,
   output logic [CPU_WIDTH-1:0] o_mem_addr,
   output logic                 o_mem_wen,
   output logic [CPU_WIDTH-1:0] o_mem_wdata,
   output logic [7:0]           o_mem_wmask,
   input  logic                 i_mem_rsp_valid,
   input  logic [CPU_WIDTH-1:0] i_mem_rdata
);

   localparam int unsigned OFF_W  = 3;
   localparam int unsigned SHAM_W = OFF_W + 3;
   localparam int unsigned MASK_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [CPU_WIDTH-1:0] exres_q, stdata_q, diffpc_q;
   logic [REG_ADDRW-1:0] rdid_q;
   logic                 rdwen_q, lden_q, sten_q;
   logic [2:0]           lsfunc_q;

   logic                 mem_op;
   logic                 accept_mem;
   logic                 is_store;
   logic [SHAM_W-1:0]    shamt;
   logic [CPU_WIDTH-1:0] ld_shifted;
   logic [CPU_WIDTH-1:0] ld_data;
   logic                 ld_sext;
   logic [MASK_W-1:0]    size_mask;
   logic [MASK_W-1:0]    st_mask;

   assign mem_op     = i_exu_lden | i_exu_sten;
   assign accept_mem = (state_q == IDLE) & i_exu_valid & mem_op;
   // A load that is also flagged as a store behaves as a pure load
   assign is_store   = sten_q & ~lden_q;
   assign shamt      = {exres_q[OFF_W-1:0], 3'b000};
   assign ld_shifted = i_mem_rdata >> shamt;
   assign ld_sext    = ~lsfunc_q[2];

   // State register and EX-field latch
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         exres_q  <= '0;
         stdata_q <= '0;
         diffpc_q <= '0;
         rdid_q   <= '0;
         rdwen_q  <= 1'b0;
         lden_q   <= 1'b0;
         sten_q   <= 1'b0;
         lsfunc_q <= 3'b000;
      end else begin
         state_q <= state_d;
         if (accept_mem) begin
            exres_q  <= i_exu_exres;
            stdata_q <= i_exu_stdata;
            diffpc_q <= i_exu_diffpc;
            rdid_q   <= i_exu_rdid;
            rdwen_q  <= i_exu_rdwen;
            lden_q   <= i_exu_lden;
            sten_q   <= i_exu_sten;
            lsfunc_q <= i_exu_lsfunc;
         end
      end
   end

   // Load extraction and store byte-mask by access size
   always_comb begin
      ld_data   = ld_shifted;
      size_mask = 8'hFF;
      case (lsfunc_q[1:0])
         2'b00: begin
            ld_data   = {{(CPU_WIDTH-8){ld_sext & ld_shifted[7]}}, ld_shifted[7:0]};
            size_mask = 8'h01;
         end
         2'b01: begin
            ld_data   = {{(CPU_WIDTH-16){ld_sext & ld_shifted[15]}}, ld_shifted[15:0]};
            size_mask = 8'h03;
         end
         2'b10: begin
            ld_data   = {{(CPU_WIDTH-32){ld_sext & ld_shifted[31]}}, ld_shifted[31:0]};
            size_mask = 8'h0F;
         end
         default: begin
            ld_data   = ld_shifted;
            size_mask = 8'hFF;
         end
      endcase
      st_mask = size_mask << exres_q[OFF_W-1:0];
   end

   // Next-state and output decode
   always_comb begin
      state_d         = state_q;
      o_exu_ready     = 1'b0;
      o_mem_req_valid = 1'b0;
      o_mem_addr      = {exres_q[CPU_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      o_mem_wen       = is_store;
      o_mem_wdata     = stdata_q << shamt;
      o_mem_wmask     = is_store ? st_mask : 8'h00;
      o_lsu_exres     = exres_q;
      o_lsu_lsres     = '0;
      o_lsu_rdid      = rdid_q;
      o_lsu_rdwen     = 1'b0;
      o_lsu_lden      = 1'b0;
      s_lsu_diffpc    = diffpc_q;

      case (state_q)
         IDLE: begin
            o_exu_ready = 1'b1;
            if (i_exu_valid) begin
               if (mem_op) begin
                  state_d = REQ;
               end else begin
                  o_lsu_exres  = i_exu_exres;
                  o_lsu_rdid   = i_exu_rdid;
                  o_lsu_rdwen  = i_exu_rdwen;
                  s_lsu_diffpc = i_exu_diffpc;
               end
            end
         end
         REQ: begin
            o_mem_req_valid = 1'b1;
            if (i_mem_req_ready) begin
               state_d = RSP;
            end
         end
         RSP: begin
            if (i_mem_rsp_valid) begin
               state_d     = IDLE;
               o_lsu_rdwen = rdwen_q;
               if (lden_q) begin
                  o_lsu_lsres = ld_data;
                  o_lsu_lden  = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_lsu_bus_fsm.sv
// Directed bench for lsu_bus_fsm: table of load/store vectors plus hand
// sequences for pass-through ops, reset abandonment and back-to-back traffic.
module tb_lsu_bus_fsm;

   logic        clk;
   logic        rst_n;
   logic        exu_valid;
   logic        exu_ready;
   logic [63:0] exu_exres;
   logic [63:0] exu_stdata;
   logic [4:0]  exu_rdid;
   logic        exu_rdwen;
   logic        exu_lden;
   logic        exu_sten;
   logic [2:0]  exu_lsfunc;
   logic [63:0] exu_diffpc;
   logic [63:0] lsu_exres;
   logic [63:0] lsu_lsres;
   logic [4:0]  lsu_rdid;
   logic        lsu_rdwen;
   logic        lsu_lden;
   logic [63:0] lsu_diffpc;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_addr;
   logic        mem_wen;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_rsp_valid;
   logic [63:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   lsu_bus_fsm #(.CPU_WIDTH(64), .REG_ADDRW(5)) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_exu_valid     (exu_valid),
      .o_exu_ready     (exu_ready),
      .i_exu_exres     (exu_exres),
      .i_exu_stdata    (exu_stdata),
      .i_exu_rdid      (exu_rdid),
      .i_exu_rdwen     (exu_rdwen),
      .i_exu_lden      (exu_lden),
      .i_exu_sten      (exu_sten),
      .i_exu_lsfunc    (exu_lsfunc),
      .i_exu_diffpc    (exu_diffpc),
      .o_lsu_exres     (lsu_exres),
      .o_lsu_lsres     (lsu_lsres),
      .o_lsu_rdid      (lsu_rdid),
      .o_lsu_rdwen     (lsu_rdwen),
      .o_lsu_lden      (lsu_lden),
      .s_lsu_diffpc    (lsu_diffpc),
      .o_mem_req_valid (mem_req_valid),
      .i_mem_req_ready (mem_req_ready),
      .o_mem_addr      (mem_addr),
      .o_mem_wen       (mem_wen),
      .o_mem_wdata     (mem_wdata),
      .o_mem_wmask     (mem_wmask),
      .i_mem_rsp_valid (mem_rsp_valid),
      .i_mem_rdata     (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        lden;
      logic        sten;
      logic        rdwen;
      logic [2:0]  lsfunc;
      logic [63:0] exres;
      logic [63:0] stdata;
      logic [63:0] rdata;
      int          req_wait;
      logic [63:0] exp_addr;
      logic [63:0] exp_wdata;
      logic [7:0]  exp_wmask;
      logic        exp_wen;
      logic [63:0] exp_lsres;
   } vec_t;

   localparam int NVEC = 12;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic ld, input logic st, input logic we,
                               input logic [2:0] f, input logic [63:0] ex,
                               input logic [63:0] sd, input logic [63:0] rd,
                               input int wt, input logic [63:0] ea,
                               input logic [63:0] ewd, input logic [7:0] em,
                               input logic ewen, input logic [63:0] elr);
      vec_t v;
      v.lden = ld; v.sten = st; v.rdwen = we; v.lsfunc = f;
      v.exres = ex; v.stdata = sd; v.rdata = rd; v.req_wait = wt;
      v.exp_addr = ea; v.exp_wdata = ewd; v.exp_wmask = em;
      v.exp_wen = ewen; v.exp_lsres = elr;
      return v;
   endfunction

   task automatic clear_inputs();
      exu_valid  = 1'b0;
      exu_exres  = '0;
      exu_stdata = '0;
      exu_rdid   = '0;
      exu_rdwen  = 1'b0;
      exu_lden   = 1'b0;
      exu_sten   = 1'b0;
      exu_lsfunc = 3'b000;
      exu_diffpc = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rdata  = '0;
   endtask

   // One full memory transaction: accept, hold REQ for req_wait stalls, retire
   task automatic run_vec(input int idx, input vec_t v);
      logic [63:0] pc;
      pc = 64'h8000_0000 + 64'(idx * 4);
      @(negedge clk);
      exu_valid  = 1'b1;
      exu_exres  = v.exres;
      exu_stdata = v.stdata;
      exu_rdid   = 5'(idx + 1);
      exu_rdwen  = v.rdwen;
      exu_lden   = v.lden;
      exu_sten   = v.sten;
      exu_lsfunc = v.lsfunc;
      exu_diffpc = pc;
      #1;
      chk($sformatf("v%0d_acc_ready", idx), 64'(exu_ready), 64'd1);
      chk($sformatf("v%0d_acc_bubble", idx), 64'(lsu_rdwen), 64'd0);
      for (int w = 0; w <= v.req_wait; w++) begin
         @(negedge clk);
         exu_valid  = 1'b0;
         exu_exres  = ~v.exres;
         exu_stdata = ~v.stdata;
         exu_lsfunc = ~v.lsfunc;
         mem_req_ready = (w == v.req_wait);
         #1;
         chk($sformatf("v%0d_req_valid_%0d", idx, w), 64'(mem_req_valid), 64'd1);
         chk($sformatf("v%0d_req_ready_%0d", idx, w), 64'(exu_ready), 64'd0);
         chk($sformatf("v%0d_addr_%0d", idx, w), mem_addr, v.exp_addr);
         chk($sformatf("v%0d_wen_%0d", idx, w), 64'(mem_wen), 64'(v.exp_wen));
         chk($sformatf("v%0d_wmask_%0d", idx, w), 64'(mem_wmask), 64'(v.exp_wmask));
         if (v.exp_wen)
            chk($sformatf("v%0d_wdata_%0d", idx, w), mem_wdata, v.exp_wdata);
      end
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rdata     = v.rdata;
      #1;
      chk($sformatf("v%0d_ret_rdwen", idx), 64'(lsu_rdwen), 64'(v.rdwen));
      chk($sformatf("v%0d_ret_lden", idx), 64'(lsu_lden), 64'(v.lden));
      chk($sformatf("v%0d_ret_lsres", idx), lsu_lsres, v.exp_lsres);
      chk($sformatf("v%0d_ret_rdid", idx), 64'(lsu_rdid), 64'(idx + 1));
      chk($sformatf("v%0d_ret_exres", idx), lsu_exres, v.exres);
      chk($sformatf("v%0d_ret_pc", idx), lsu_diffpc, pc);
      chk($sformatf("v%0d_ret_ready", idx), 64'(exu_ready), 64'd0);
      chk($sformatf("v%0d_ret_reqv", idx), 64'(mem_req_valid), 64'd0);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rdata     = '0;
      #1;
      chk($sformatf("v%0d_post_ready", idx), 64'(exu_ready), 64'd1);
      chk($sformatf("v%0d_post_rdwen", idx), 64'(lsu_rdwen), 64'd0);
   endtask

   initial begin
      vecs[0]  = mk(1, 0, 1, 3'b000, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 0,
                    64'h8000_0000, 64'h0, 8'h00, 0, 64'hFFFF_FFFF_FFFF_FF80);
      vecs[1]  = mk(0, 1, 0, 3'b001, 64'h8000_0006, 64'hBEEF, 64'h0, 3,
                    64'h8000_0000, 64'hBEEF_0000_0000_0000, 8'hC0, 1, 64'h0);
      vecs[2]  = mk(1, 0, 1, 3'b110, 64'h8000_0004, 64'h0, 64'hF00D_CAFE_0000_0000, 1,
                    64'h8000_0000, 64'h0, 8'h00, 0, 64'h0000_0000_F00D_CAFE);
      vecs[3]  = mk(1, 0, 1, 3'b010, 64'h8000_0004, 64'h0, 64'hF00D_CAFE_0000_0000, 0,
                    64'h8000_0000, 64'h0, 8'h00, 0, 64'hFFFF_FFFF_F00D_CAFE);
      vecs[4]  = mk(1, 0, 1, 3'b001, 64'h1002, 64'h0, 64'h0000_0000_8001_0000, 0,
                    64'h1000, 64'h0, 8'h00, 0, 64'hFFFF_FFFF_FFFF_8001);
      vecs[5]  = mk(1, 0, 1, 3'b101, 64'h1002, 64'h0, 64'h0000_0000_8001_0000, 0,
                    64'h1000, 64'h0, 8'h00, 0, 64'h0000_0000_0000_8001);
      vecs[6]  = mk(1, 0, 1, 3'b011, 64'h2000, 64'h0, 64'h0123_4567_89AB_CDEF, 0,
                    64'h2000, 64'h0, 8'h00, 0, 64'h0123_4567_89AB_CDEF);
      vecs[7]  = mk(1, 0, 1, 3'b100, 64'h2007, 64'h0, 64'hAB00_0000_0000_0000, 0,
                    64'h2000, 64'h0, 8'h00, 0, 64'h0000_0000_0000_00AB);
      vecs[8]  = mk(0, 1, 1, 3'b011, 64'h3000, 64'h1122_3344_5566_7788, 64'h0, 0,
                    64'h3000, 64'h1122_3344_5566_7788, 8'hFF, 1, 64'h0);
      vecs[9]  = mk(0, 1, 0, 3'b010, 64'h3006, 64'hDEAD_BEEF, 64'h0, 0,
                    64'h3000, 64'hBEEF_0000_0000_0000, 8'hC0, 1, 64'h0);
      vecs[10] = mk(0, 1, 1, 3'b000, 64'h3005, 64'hA5, 64'h0, 1,
                    64'h3000, 64'h0000_A500_0000_0000, 8'h20, 1, 64'h0);
      vecs[11] = mk(1, 1, 1, 3'b000, 64'h4001, 64'h0, 64'h0000_0000_0000_7F00, 0,
                    64'h4000, 64'h0, 8'h00, 0, 64'h0000_0000_0000_007F);

      clear_inputs();
      rst_n = 1'b0;
      #3;
      chk("rst_ready", 64'(exu_ready), 64'd1);
      chk("rst_reqv", 64'(mem_req_valid), 64'd0);
      chk("rst_rdwen", 64'(lsu_rdwen), 64'd0);
      chk("rst_lden", 64'(lsu_lden), 64'd0);
      chk("rst_addr", mem_addr, 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Non-memory op retires in the accepting cycle
      @(negedge clk);
      exu_valid  = 1'b1;
      exu_exres  = 64'h1234;
      exu_rdid   = 5'd5;
      exu_rdwen  = 1'b1;
      exu_diffpc = 64'h8000_0100;
      #1;
      chk("add_exres", lsu_exres, 64'h1234);
      chk("add_rdid", 64'(lsu_rdid), 64'd5);
      chk("add_rdwen", 64'(lsu_rdwen), 64'd1);
      chk("add_lsres", lsu_lsres, 64'h0);
      chk("add_lden", 64'(lsu_lden), 64'd0);
      chk("add_pc", lsu_diffpc, 64'h8000_0100);
      @(negedge clk);
      clear_inputs();
      mem_rsp_valid = 1'b1;
      mem_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      chk("add_idle_ready", 64'(exu_ready), 64'd1);
      chk("add_idle_reqv", 64'(mem_req_valid), 64'd0);
      chk("idle_rsp_rdwen", 64'(lsu_rdwen), 64'd0);
      chk("idle_rsp_lden", 64'(lsu_lden), 64'd0);
      @(negedge clk);
      clear_inputs();
      #1;
      chk("idle_still", 64'(exu_ready), 64'd1);

      for (int i = 0; i < NVEC; i++) begin
         run_vec(i, vecs[i]);
      end

      // Reset while in RSP abandons the op; a late response is ignored
      @(negedge clk);
      clear_inputs();
      exu_valid  = 1'b1;
      exu_lden   = 1'b1;
      exu_lsfunc = 3'b011;
      exu_exres  = 64'h5000;
      exu_rdwen  = 1'b1;
      exu_rdid   = 5'd7;
      mem_req_ready = 1'b1;
      @(negedge clk);
      exu_valid = 1'b0;
      #1;
      chk("rr_req", 64'(mem_req_valid), 64'd1);
      @(negedge clk);
      mem_req_ready = 1'b0;
      #1;
      chk("rr_rsp_ready", 64'(exu_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("rr_ready", 64'(exu_ready), 64'd1);
      chk("rr_reqv", 64'(mem_req_valid), 64'd0);
      chk("rr_rdwen", 64'(lsu_rdwen), 64'd0);
      chk("rr_addr", mem_addr, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rdata     = 64'h1111_2222_3333_4444;
      #1;
      chk("rr_late_rdwen", 64'(lsu_rdwen), 64'd0);
      chk("rr_late_lden", 64'(lsu_lden), 64'd0);
      chk("rr_late_ready", 64'(exu_ready), 64'd1);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      #1;
      chk("rr_after_reqv", 64'(mem_req_valid), 64'd0);
      chk("rr_after_ready", 64'(exu_ready), 64'd1);

      // Back-to-back LD with valid, ready and rsp_valid held high
      @(negedge clk);
      clear_inputs();
      exu_valid  = 1'b1;
      exu_lden   = 1'b1;
      exu_lsfunc = 3'b011;
      exu_exres  = 64'h6008;
      exu_rdwen  = 1'b1;
      exu_rdid   = 5'd9;
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rdata     = 64'hCAFE_BABE_1234_5678;
      for (int k = 0; k < 9; k++) begin
         #1;
         case (k % 3)
            0: begin
               chk($sformatf("b2b_%0d_ready", k), 64'(exu_ready), 64'd1);
               chk($sformatf("b2b_%0d_rdwen", k), 64'(lsu_rdwen), 64'd0);
               chk($sformatf("b2b_%0d_lden", k), 64'(lsu_lden), 64'd0);
            end
            1: begin
               chk($sformatf("b2b_%0d_ready", k), 64'(exu_ready), 64'd0);
               chk($sformatf("b2b_%0d_reqv", k), 64'(mem_req_valid), 64'd1);
               chk($sformatf("b2b_%0d_rdwen", k), 64'(lsu_rdwen), 64'd0);
            end
            default: begin
               chk($sformatf("b2b_%0d_ready", k), 64'(exu_ready), 64'd0);
               chk($sformatf("b2b_%0d_rdwen", k), 64'(lsu_rdwen), 64'd1);
               chk($sformatf("b2b_%0d_lden", k), 64'(lsu_lden), 64'd1);
               chk($sformatf("b2b_%0d_lsres", k), lsu_lsres, 64'hCAFE_BABE_1234_5678);
               chk($sformatf("b2b_%0d_addr", k), mem_addr, 64'h6008);
            end
         endcase
         @(negedge clk);
      end
      clear_inputs();
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lsu_bus_fsm.md
LSU_BUS_FSM -- requirements
Module: lsu_bus_fsm

Interface
REQ-001 Parameter CPU_WIDTH, default 64, SHALL set the data, address and PC width.
REQ-002 Parameter REG_ADDRW, default 5, SHALL set the destination register index width.
REQ-003 i_clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 i_rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 i_exu_valid / o_exu_ready  in/out  1/1  SHALL be the EX-side handshake; an op is accepted when both are high.
REQ-006 i_exu_exres  in  CPU_WIDTH  SHALL carry the ALU result, which is also the memory address.
REQ-007 i_exu_stdata  in  CPU_WIDTH  SHALL carry the unaligned store data.
REQ-008 i_exu_rdid, i_exu_rdwen  in  REG_ADDRW, 1  SHALL carry the destination register index and its write enable.
REQ-009 i_exu_lden, i_exu_sten  in  1, 1  SHALL flag a load or a store.
REQ-010 i_exu_lsfunc  in  3  SHALL encode the access: [1:0] size (00 B, 01 H, 10 W, 11 D); [2] unsigned load.
REQ-011 i_exu_diffpc  in  CPU_WIDTH  SHALL carry the difftest PC.
REQ-012 o_lsu_exres, o_lsu_lsres, o_lsu_rdid, o_lsu_rdwen, o_lsu_lden, s_lsu_diffpc  out  CPU_WIDTH, CPU_WIDTH, REG_ADDRW, 1, 1, CPU_WIDTH  SHALL drive the LS/WB pipeline register, which is always enabled.
REQ-013 o_mem_req_valid / i_mem_req_ready  out/in  1/1  SHALL be the memory request handshake.
REQ-014 o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask  out  CPU_WIDTH, 1, CPU_WIDTH, 8  SHALL carry the request fields.
REQ-015 i_mem_rsp_valid, i_mem_rdata  in  1, CPU_WIDTH  SHALL carry the single-cycle response: load data, or a write acknowledge.

Function
REQ-016 The FSM SHALL have three states: IDLE, REQ, RSP.
REQ-017 In IDLE, o_exu_ready SHALL be 1; in REQ and RSP it SHALL be 0.
REQ-018 A non-memory op (lden=0, sten=0) accepted in IDLE SHALL appear on the o_lsu_* outputs combinationally in the same cycle with lsres=0 and lden=0; the state SHALL stay IDLE.
REQ-019 A memory op accepted in IDLE SHALL latch all EX fields and move to REQ; o_lsu_rdwen SHALL be 0 (bubble) in that cycle.
REQ-020 Whenever no op is retiring, o_lsu_rdwen and o_lsu_lden SHALL be 0 and the other o_lsu_* outputs SHALL be don't-care.
REQ-021 In REQ, o_mem_req_valid SHALL be 1 and all request fields SHALL be held stable until i_mem_req_ready=1; then the state SHALL move to RSP.
REQ-022 o_mem_addr SHALL be {exres[CPU_WIDTH-1:3], 3'b000}.
REQ-023 For stores, o_mem_wdata SHALL be stdata << (8*exres[2:0]), and o_mem_wmask SHALL be the size mask (0x01/0x03/0x0F/0xFF) << exres[2:0], truncated to 8 bits.
REQ-024 For loads, o_mem_wen and o_mem_wmask SHALL be 0.
REQ-025 In RSP, the state SHALL wait for i_mem_rsp_valid. On that cycle the block SHALL retire the latched op on the o_lsu_* outputs and return to IDLE.
REQ-026 On retire, load data SHALL be rdata >> (8*exres[2:0]), truncated to the access size, then zero-extended if lsfunc[2]=1 and sign-extended otherwise.
REQ-027 On retire, a store SHALL drive lsres=0 and lden=0, and SHALL pass rdwen through unchanged.
REQ-028 If lden and sten are both 1, the op SHALL be treated as a load.
REQ-029 Misalignment SHALL NOT be checked; bytes beyond bit 63 SHALL be dropped.
REQ-030 i_mem_rsp_valid outside RSP SHALL be ignored.
REQ-031 i_exu_valid SHALL be ignored in REQ and RSP.
REQ-032 Minimum memory-op latency SHALL be 2 cycles from acceptance to retire (REQ with ready=1, then RSP with rsp_valid=1).

Reset
REQ-033 While i_rst_n=0, the state SHALL be IDLE, all latched fields 0, o_mem_req_valid=0, o_lsu_rdwen=0 and o_lsu_lden=0.
REQ-034 Asserting reset during REQ or RSP SHALL abandon the op; a response arriving after reset release SHALL be ignored.

Verification
REQ-035 ADD op: exres=0x1234, rdid=5, rdwen=1 -> retires in the same cycle; lsres=0; state stays IDLE.
REQ-036 LB: exres=0x80000003, lsfunc=000, rdata=0x00000000_80000000 in the byte 3 position, ready=1 -> lsres=0xFFFFFFFF_FFFFFF80, lden=1, 2 cycles after acceptance.
REQ-037 SH: exres=0x80000006, stdata=0xBEEF -> o_mem_addr=0x80000000, wdata=0xBEEF<<48, wmask=0xC0, wen=1; request held for 3 cycles with ready=0.
REQ-038 LWU: exres=0x80000004, rdata=0xF00DCAFE_00000000 -> lsres=0x00000000_F00DCAFE.
REQ-039 Reset asserted in RSP, then a late rsp_valid -> no retire; IDLE; o_exu_ready=1.
REQ-040 Back-to-back LD ops with ready=1 and rsp_valid=1 -> one retire every 3 cycles; o_exu_ready=0 in REQ and RSP.
